// File: rtl/mips_muldiv_pkg.sv
// Shared types for the MIPS multiply/divide unit.
package mips_muldiv_pkg;
  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } muldiv_state_t;
endpackage

// File: rtl/mips_muldiv_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
module mips_div_step
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] trial;

  always_comb begin
    trial   = {rem_in, dvd_bit};
    q_bit   = (trial >= {1'b0, divisor});
    // low bits of the difference are exact modulo 2^WIDTH
    rem_out = q_bit ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];
  end
endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS mul/div unit owning HI/LO.
// MIPS_MULDIV_FAST_MULT_EN selects a single-cycle combinational multiply.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [OP_W-1:0]  op_code,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  muldiv_op_t       op;
  logic             sgn_op;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mul_acc, mul_shf;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] div_rem, div_shf;
  logic             div_q;
  logic [WIDTH-1:0] quo_s, rem_s;
  logic             last;
`ifdef MIPS_MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  mips_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc_q),
    .dvd_bit (shf_q[WIDTH-1]),
    .divisor (opa_q),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  always_comb begin
    op     = muldiv_op_t'(op_code);
    sgn_op = (op == OP_MULT) || (op == OP_DIV);
    mag_a  = (sgn_op && src_a[WIDTH-1]) ? -src_a : src_a;
    mag_b  = (sgn_op && src_b[WIDTH-1]) ? -src_b : src_b;
`ifdef MIPS_MULDIV_FAST_MULT_EN
    if (op == OP_MULT)
      fast_prod = {{WIDTH{src_a[WIDTH-1]}}, src_a}
                * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    else
      fast_prod = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
`endif
  end

  // shift-add: {acc,shf} is the running product, multiplier in shf
  always_comb begin
    addend  = shf_q[0] ? opa_q : '0;
    sum     = {1'b0, acc_q} + {1'b0, addend};
    mul_acc = sum[WIDTH:1];
    mul_shf = {sum[0], shf_q[WIDTH-1:1]};
    prod    = {mul_acc, mul_shf};
    prod_s  = neg_q ? -prod : prod;
    div_shf = {shf_q[WIDTH-2:0], div_q};
    quo_s   = neg_q ? -div_shf : div_shf;
    rem_s   = rneg_q ? -div_rem : div_rem;
    last    = (cnt_q == CNT_W'(1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shf_d   = shf_q;
    opa_d   = opa_q;
    raw_d   = raw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MULT, OP_MULTU: begin
`ifdef MIPS_MULDIV_FAST_MULT_EN
              {hi_d, lo_d} = fast_prod;
              done_d       = 1'b1;
`else
              state_d = MUL_RUN;
              cnt_d   = CNT_W'(WIDTH);
              acc_d   = '0;
              opa_d   = mag_a;
              shf_d   = mag_b;
              neg_d   = sgn_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`endif
            end
            OP_DIV, OP_DIVU: begin
              state_d = DIV_RUN;
              cnt_d   = CNT_W'(WIDTH);
              acc_d   = '0;
              opa_d   = mag_b;
              shf_d   = mag_a;
              raw_d   = src_a;
              neg_d   = sgn_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              rneg_d  = sgn_op && src_a[WIDTH-1];
              dz_d    = (src_b == '0);
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      MUL_RUN: begin
        acc_d = mul_acc;
        shf_d = mul_shf;
        cnt_d = cnt_q - CNT_W'(1);
        if (last) begin
          {hi_d, lo_d} = prod_s;
          state_d      = IDLE;
          done_d       = 1'b1;
        end
      end
      DIV_RUN: begin
        acc_d = div_rem;
        shf_d = div_shf;
        cnt_d = cnt_q - CNT_W'(1);
        if (last) begin
          hi_d    = dz_q ? raw_q : rem_s;
          lo_d    = dz_q ? '1 : quo_s;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      shf_q   <= '0;
      opa_q   <= '0;
      raw_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shf_q   <= shf_d;
      opa_q   <= opa_d;
      raw_q   <= raw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit (WIDTH=32).
module tb_mips_muldiv_unit;
  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

`ifdef MIPS_MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_code  (op_code),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    op_valid = 1'b1;
    op_code  = op;
    src_a    = a;
    src_b    = b;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (busy === 1'b1 && lat < 200) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el,
                     input int elat);
    int lat;
    issue(op, a, b);
    wait_done(lat);
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int lat;
    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = 3'd0;
    src_a    = '0;
    src_b    = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run("multu max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFE, 32'h00000001, MUL_LAT);
    @(negedge clk);
    chk("multu done one cycle", 64'(done), 64'd0);

    // back-to-back issues land in the done cycle of the previous op
    run("mult -3x5", 3'd0, 32'hFFFFFFFD, 32'd5,
        32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT);
    run("mult -4x-4", 3'd0, 32'hFFFFFFFC, 32'hFFFFFFFC,
        32'h0, 32'h10, MUL_LAT);
    run("div -7/2", 3'd2, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT);
    run("divu 7/2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, DIV_LAT);
    run("divu by0", 3'd3, 32'h1234, 32'd0,
        32'h1234, 32'hFFFFFFFF, DIV_LAT);
    run("div min/-1", 3'd2, 32'h80000000, 32'hFFFFFFFF,
        32'h0, 32'h80000000, DIV_LAT);
    run("div -5/0", 3'd2, 32'hFFFFFFFB, 32'd0,
        32'hFFFFFFFB, 32'hFFFFFFFF, DIV_LAT);

    op_valid = 1'b1;
    op_code  = 3'd4;
    src_a    = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    op_code = 3'd5;
    src_a   = 32'h1;
    chk("mthi hi", 64'(hi), 64'hDEADBEEF);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    chk("mtlo lo", 64'(lo), 64'd1);
    chk("mtlo hi kept", 64'(hi), 64'hDEADBEEF);
    chk("mtlo busy", 64'(busy), 64'd0);

    op_valid = 1'b1;
    op_code  = 3'd6;
    src_a    = 32'h99;
    src_b    = 32'h3;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    chk("op6 busy", 64'(busy), 64'd0);
    chk("op6 hilo", {32'(hi), 32'(lo)}, {32'hDEADBEEF, 32'h1});

    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    repeat (5) @(negedge clk);
    op_valid = 1'b1;
    op_code  = 3'd4;
    src_a    = 32'h55;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    chk("mthi mid-div hi hold", 64'(hi), 64'hDEADBEEF);
    wait_done(lat);
    chk("mid-div done", 64'(done), 64'd1);
    chk("mid-div hi", 64'(hi), 64'hFFFFFFFF);
    chk("mid-div lo", 64'(lo), 64'hFFFFFFFD);
    @(negedge clk);

    issue(3'd1, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    @(negedge clk);
    chk("abort no late done", 64'(done), 64'd0);

    run("divu 10/3", 3'd3, 32'd10, 32'd3, 32'd1, 32'd3, DIV_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Replaces the single-cycle HILO path in the ALU.
- Executes MULT/MULTU/DIV/DIVU iteratively over WIDTH cycles, plus single-cycle MTHI/MTLO.
- Exposes HI/LO continuously for MFHI/MFLO; signals busy so the pipeline stalls HI/LO consumers and new mul/div issue.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits; legal values are 4 or more.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  operation request this cycle.
- op_code  in  3  muldiv_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6-7 are ignored.
- src_a  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- src_b  in  WIDTH  multiplier / divisor.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse: HI/LO just updated by mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- Accept rule: an op is accepted at a rising edge when op_valid=1 and busy=0.
  - op_valid while busy=1 is ignored; the upstream stage must hold or stall.
  - op_code 6-7 is ignored and nothing changes.
- MTHI/MTLO:
  - At the accept edge, hi (resp. lo) <= src_a.
  - busy stays 0 and done stays 0.
  - The new value is visible the next cycle.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
  - IDLE -> MUL_RUN on accepted MULT/MULTU.
  - IDLE -> DIV_RUN on accepted DIV/DIVU.
  - On entry, operands are latched and converted to magnitudes for signed ops, sign flags are stored, and counter=WIDTH.
  - RUN states: one iteration per cycle; counter decrements each cycle.
  - When counter reaches 1, the next edge writes hi/lo, returns to IDLE, and sets done=1 for exactly one cycle.
- Latency: accept at edge E0; busy=1 in cycles after E0 through E_WIDTH; at E_WIDTH, hi/lo are written, busy=0 and done=1. hi/lo are unchanged while busy.
- Back-to-back: a new op may be accepted in the done cycle.
- Multiply:
  - Shift-add over WIDTH iterations producing a 2*WIDTH product; {hi,lo} <= product.
  - Signed: the product is negated if the sign flags differ.
- Divide:
  - Restoring, one quotient bit per iteration; lo <= quotient, hi <= remainder.
  - Signed: truncates toward zero; remainder takes the dividend's sign.
- Divide boundary cases (full iteration latency is still taken):
  - Divisor=0: hi <= src_a, lo <= all ones.
  - Signed MIN / -1: lo <= MIN, hi <= 0, no exception.
- Reset mid-operation: aborts immediately at the edge; no done pulse; hi/lo are cleared.
- Simultaneous reset and op_valid: reset wins.

Optional Feature:
- Macro: MIPS_MULDIV_FAST_MULT_EN.
- Defined: MULT/MULTU complete combinationally at the accept edge ({hi,lo} <= full product). busy stays 0, done pulses in the following cycle, and MUL_RUN is unused. Divide is unchanged.
- Undefined: iterative WIDTH-cycle multiply as above.

Decomposition:
- Package mips_muldiv_pkg:
  - muldiv_op_t enum (3-bit, values above).
  - muldiv_state_t enum (IDLE, MUL_RUN, DIV_RUN).
  - Localparam OP_W=3.
- Sub-module mips_div_step: purely combinational single restoring-division iteration.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Parametrised by WIDTH.

Test Plan (WIDTH=32):
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done high exactly 1 cycle.
- MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT -4 x -4 -> hi=0, lo=0x10.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 2 -> lo=3, hi=1, 32-cycle latency.
- DIVU 0x1234 / 0 -> hi=0x1234, lo=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0xDEADBEEF then MTLO 0x1 on consecutive cycles -> hi/lo updated next cycle, busy=0; MTHI issued mid-DIV is ignored and hi reflects the DIV result.
- Reset asserted in busy cycle 10 of MULTU -> next cycle busy=0, done=0, hi=lo=0; a following DIVU 10/3 gives lo=3, hi=1.
